// File: rtl/pio_in_debounce_irq_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
// The host side drives address/strobe/data and samples readdata one cycle later.
interface pio_in_debounce_irq_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/pio_in_debounce_irq.sv
// Debounced input PIO for board switches and keys.
// Raw pins pass through a synchroniser and then a per-bit stability filter.
// Filtered edges are latched into a write-1-to-clear capture register,
// which drives a maskable level interrupt.
module pio_in_debounce_irq #(
   parameter int WIDTH           = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int EDGE_TYPE       = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   pio_in_debounce_irq_if.slave  bus,
   input  logic [WIDTH-1:0]      in_port,
   output logic                  irq
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  s;
   logic [WIDTH-1:0]                  deb;
   logic [WIDTH-1:0]                  deb_d;
   logic [WIDTH-1:0]                  edge_set;
   logic [WIDTH-1:0]                  edge_capture;
   logic [WIDTH-1:0]                  irq_mask;
   logic [WIDTH-1:0]                  clear_bits;
   logic [31:0]                       rd_next;
   logic                              wr_en;
   logic                              unused_wd;

   // Shift the raw pins through the synchroniser chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign deb = s;
      end else begin : g_filter
         localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

         logic [CNT_W-1:0] cnt [WIDTH];
         logic [WIDTH-1:0] deb_q;

         // Accept a new level only after it has differed from the current one for N straight cycles.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               deb_q <= '0;
               for (int i = 0; i < WIDTH; i++) begin
                  cnt[i] <= '0;
               end
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (s[i] == deb_q[i]) begin
                     cnt[i] <= '0;
                  end else if (cnt[i] == CNT_LAST) begin
                     deb_q[i] <= s[i];
                     cnt[i]   <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + 1'b1;
                  end
               end
            end
         end

         assign deb = deb_q;
      end
   endgenerate

   assign wr_en     = bus.chipselect & ~bus.write_n;
   assign unused_wd = &{1'b0, bus.writedata};

   // Pick which filtered transitions count as events.
   always_comb begin
      edge_set = '0;
      if (EDGE_TYPE == 0) begin
         edge_set = deb & ~deb_d;
      end else if (EDGE_TYPE == 1) begin
         edge_set = ~deb & deb_d;
      end else begin
         edge_set = deb ^ deb_d;
      end
   end

   // Bits that software asks to clear this edge.
   always_comb begin
      clear_bits = '0;
      if (wr_en && bus.address == 2'd3) begin
         clear_bits = bus.writedata[WIDTH-1:0];
      end
   end

   // Delay the filtered value by one cycle for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_d <= '0;
      end else begin
         deb_d <= deb;
      end
   end

   // Capture register: a new edge beats a simultaneous software clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture <= '0;
      end else begin
         edge_capture <= (edge_capture & ~clear_bits) | edge_set;
      end
   end

   // Interrupt mask register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
      end else if (wr_en && bus.address == 2'd2) begin
         irq_mask <= bus.writedata[WIDTH-1:0];
      end
   end

   // Read mux sees register state from before any write on the same edge.
   always_comb begin
      rd_next = '0;
      case (bus.address)
         2'd0:    rd_next[WIDTH-1:0] = deb;
         2'd2:    rd_next[WIDTH-1:0] = irq_mask;
         2'd3:    rd_next[WIDTH-1:0] = edge_capture;
         default: rd_next = '0;
      endcase
   end

   // Register read data every cycle regardless of chipselect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.readdata <= '0;
      end else begin
         bus.readdata <= rd_next;
      end
   end

   assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// Bench for the debounced input PIO: a default 10-bit filtered instance and
// a 32-bit unfiltered any-edge instance, both checked every cycle against a
// history-window model, plus hand-computed spot checks.
module tb_pio_in_debounce_irq;

   logic        clk;
   logic        reset_n;
   logic [9:0]  in0;
   logic [31:0] in1;
   logic        irq0;
   logic        irq1;

   int total;
   int bad;

   pio_in_debounce_irq_if bus0 ();
   pio_in_debounce_irq_if bus1 ();

   pio_in_debounce_irq #(
      .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
   ) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .irq(irq0)
   );

   pio_in_debounce_irq #(
      .WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in1), .irq(irq1)
   );

   // Model parameters per instance.
   int p_w    [2] = '{10, 32};
   int p_sync [2] = '{2, 2};
   int p_n    [2] = '{4, 0};
   int p_edge [2] = '{0, 2};

   // Model state: pin sample history (index 0 = newest) and register values after each edge.
   logic [31:0] m_hist [2][16];
   logic [31:0] m_deb  [2];
   logic [31:0] m_debd [2];
   logic [31:0] m_cap  [2];
   logic [31:0] m_mask [2];
   logic [31:0] m_rd   [2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 16; j++) m_hist[k][j] = '0;
         m_deb[k]  = '0;
         m_debd[k] = '0;
         m_cap[k]  = '0;
         m_mask[k] = '0;
         m_rd[k]   = '0;
      end
   endtask

   // A level is accepted once the last N synchronised samples all disagree with it.
   task automatic model_step(input int k, input logic [31:0] inp, input logic [1:0] addr,
                             input logic cs, input logic wn, input logic [31:0] wd);
      logic [31:0] wm, old_deb, old_debd, old_cap, old_mask, flip, setv, chg;
      wm       = (p_w[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << p_w[k]) - 32'd1);
      old_deb  = m_deb[k];
      old_debd = m_debd[k];
      old_cap  = m_cap[k];
      old_mask = m_mask[k];
      case (addr)
         2'd0:    m_rd[k] = old_deb;
         2'd2:    m_rd[k] = old_mask;
         2'd3:    m_rd[k] = old_cap;
         default: m_rd[k] = 32'd0;
      endcase
      for (int j = 15; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = inp & wm;
      if (p_n[k] == 0) begin
         m_deb[k] = m_hist[k][p_sync[k]-1];
      end else begin
         flip = wm;
         for (int j = 0; j < p_n[k]; j++) flip &= (m_hist[k][p_sync[k]+j] ^ old_deb);
         m_deb[k] = old_deb ^ flip;
      end
      chg = old_deb ^ old_debd;
      if (p_edge[k] == 0)      setv = chg & old_deb;
      else if (p_edge[k] == 1) setv = chg & ~old_deb;
      else                     setv = chg;
      if (cs && !wn && addr == 2'd2) m_mask[k] = wd & wm;
      if (cs && !wn && addr == 2'd3) m_cap[k] = (old_cap & ~wd) | setv;
      else                           m_cap[k] = old_cap | setv;
      m_debd[k] = old_deb;
   endtask

   // Advance the model on every clock edge, clearing it with reset.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         model_clear();
      end else begin
         model_step(0, {22'd0, in0}, bus0.address, bus0.chipselect, bus0.write_n, bus0.writedata);
         model_step(1, in1, bus1.address, bus1.chipselect, bus1.write_n, bus1.writedata);
      end
   end

   // Compare both instances against the model shortly after every edge.
   always @(posedge clk) begin
      #2;
      check_output("model_rd0",  bus0.readdata, m_rd[0]);
      check_output("model_irq0", {31'd0, irq0}, {31'd0, |(m_cap[0] & m_mask[0])});
      check_output("model_rd1",  bus1.readdata, m_rd[1]);
      check_output("model_irq1", {31'd0, irq1}, {31'd0, |(m_cap[1] & m_mask[1])});
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic apply_stimulus(input int k, input logic [1:0] a, input logic cs,
                                 input logic wn, input logic [31:0] d);
      if (k == 0) begin
         bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = d;
      end else begin
         bus1.address = a; bus1.chipselect = cs; bus1.write_n = wn; bus1.writedata = d;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      total = 0;
      bad   = 0;
      model_clear();
      reset_n = 1'b0;
      in0 = 10'h3FF;
      in1 = 32'd0;
      apply_stimulus(0, 2'd0, 1'b0, 1'b1, 32'd0);
      apply_stimulus(1, 2'd0, 1'b0, 1'b1, 32'd0);

      // Reset held with all pins high: every address reads 0, no interrupt.
      for (int a = 0; a < 4; a++) begin
         apply_stimulus(0, 2'(a), 1'b0, 1'b1, 32'd0);
         tick(1);
         check_output("reset_rd", bus0.readdata, 32'd0);
         check_output("reset_irq", {31'd0, irq0}, 32'd0);
      end
      apply_stimulus(0, 2'd0, 1'b0, 1'b1, 32'd0);

      // Release, then reset again while the filter is counting.
      reset_n = 1'b1;
      tick(4);
      check_output("midcount_before", bus0.readdata, 32'd0);
      reset_n = 1'b0;
      #1;
      check_output("midcount_async", bus0.readdata, 32'd0);
      tick(3);
      check_output("midcount_held", bus0.readdata, 32'd0);

      // Pins high out of reset: DATA rises after 2 + 4 + 1 edges.
      reset_n = 1'b1;
      tick(6);
      check_output("powerup_before", bus0.readdata, 32'd0);
      tick(1);
      check_output("powerup_rise", bus0.readdata, 32'h3FF);
      in0 = 10'h000;
      tick(8);
      apply_stimulus(0, 2'd3, 1'b1, 1'b0, 32'h3FF);
      tick(1);
      apply_stimulus(0, 2'd0, 1'b0, 1'b1, 32'd0);
      tick(2);

      // Clean step on bit 0.
      in0 = 10'h001;
      tick(6);
      check_output("step_before", bus0.readdata, 32'd0);
      tick(1);
      check_output("step_latency", bus0.readdata, 32'h001);
      apply_stimulus(0, 2'd3, 1'b0, 1'b1, 32'd0);
      tick(1);
      check_output("step_capture", bus0.readdata, 32'h001);
      apply_stimulus(0, 2'd3, 1'b1, 1'b0, 32'h001);
      tick(1);
      apply_stimulus(0, 2'd0, 1'b0, 1'b1, 32'd0);
      in0 = 10'h000;
      tick(8);

      // Bounce: high 3, low 1, high 5; only the second run is accepted.
      in0 = 10'h001;
      tick(3);
      in0 = 10'h000;
      tick(1);
      in0 = 10'h001;
      tick(5);
      check_output("bounce_hold", bus0.readdata, 32'd0);
      tick(1);
      check_output("bounce_hold2", bus0.readdata, 32'd0);
      tick(1);
      check_output("bounce_rise", bus0.readdata, 32'h001);
      apply_stimulus(0, 2'd3, 1'b0, 1'b1, 32'd0);
      tick(1);
      check_output("bounce_cap", bus0.readdata, 32'h001);

      // A write strobe without chipselect must not touch the mask.
      apply_stimulus(0, 2'd2, 1'b0, 1'b0, 32'h001);
      tick(1);
      check_output("nocs_irq", {31'd0, irq0}, 32'd0);

      // Enable the interrupt, then probe W1C behaviour.
      apply_stimulus(0, 2'd2, 1'b1, 1'b0, 32'h001);
      tick(1);
      check_output("mask_irq", {31'd0, irq0}, 32'd1);
      apply_stimulus(0, 2'd3, 1'b1, 1'b0, 32'h000);
      tick(1);
      check_output("w0_keeps", {31'd0, irq0}, 32'd1);
      apply_stimulus(0, 2'd3, 1'b0, 1'b1, 32'd0);
      tick(1);
      check_output("w0_cap", bus0.readdata, 32'h001);
      apply_stimulus(0, 2'd3, 1'b1, 1'b0, 32'h001);
      tick(1);
      check_output("w1c_irq", {31'd0, irq0}, 32'd0);
      apply_stimulus(0, 2'd3, 1'b0, 1'b1, 32'd0);
      tick(1);
      check_output("w1c_cap", bus0.readdata, 32'd0);

      // Collision: clear bit 0 on the same edge a new rise is captured.
      apply_stimulus(0, 2'd0, 1'b0, 1'b1, 32'd0);
      in0 = 10'h000;
      tick(8);
      check_output("fall_no_irq", {31'd0, irq0}, 32'd0);
      in0 = 10'h001;
      tick(6);
      apply_stimulus(0, 2'd3, 1'b1, 1'b0, 32'h001);
      tick(1);
      apply_stimulus(0, 2'd3, 1'b0, 1'b1, 32'd0);
      check_output("collision_irq", {31'd0, irq0}, 32'd1);
      tick(1);
      check_output("collision_cap", bus0.readdata, 32'h001);

      // Wide unfiltered any-edge instance.
      in1 = 32'h8000_0000;
      tick(2);
      check_output("w32_before", bus1.readdata, 32'd0);
      tick(1);
      check_output("w32_latency", bus1.readdata, 32'h8000_0000);
      apply_stimulus(1, 2'd3, 1'b0, 1'b1, 32'd0);
      tick(1);
      check_output("w32_rise_cap", bus1.readdata, 32'h8000_0000);
      apply_stimulus(1, 2'd2, 1'b1, 1'b0, 32'h8000_0000);
      tick(1);
      check_output("w32_irq", {31'd0, irq1}, 32'd1);
      apply_stimulus(1, 2'd3, 1'b1, 1'b0, 32'h8000_0000);
      tick(1);
      apply_stimulus(1, 2'd3, 1'b0, 1'b1, 32'd0);
      check_output("w32_cleared", {31'd0, irq1}, 32'd0);
      in1 = 32'd0;
      tick(3);
      check_output("w32_fall_irq", {31'd0, irq1}, 32'd1);
      tick(1);
      check_output("w32_fall_cap", bus1.readdata, 32'h8000_0000);
      apply_stimulus(1, 2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF);
      tick(1);
      apply_stimulus(1, 2'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
      tick(1);
      apply_stimulus(1, 2'd1, 1'b0, 1'b1, 32'd0);
      tick(1);
      check_output("w32_reserved", bus1.readdata, 32'd0);
      apply_stimulus(1, 2'd0, 1'b0, 1'b1, 32'd0);
      tick(1);
      check_output("w32_data_ro", bus1.readdata, 32'd0);
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pio_in_debounce_irq.md
Name: pio_in_debounce_irq

Overview:
Parametrised Avalon-MM slave input port for board switches and keys. It is the successor to the fixed 10-bit read-only switch PIO. It adds:
- configurable width
- a metastability synchroniser
- a per-bit debounce filter
- per-bit edge capture with write-1-to-clear
- an interrupt mask and level interrupt output

It sits between the DE10-Lite switch/key pins and the SOPC interconnect.

Parameters:
WIDTH, 10, number of input bits (1..32)
SYNC_STAGES, 2, synchroniser flops per bit (2..4)
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a new level; 0 = filter bypassed
EDGE_TYPE, 0, edge that sets capture: 0 = rising, 1 = falling, 2 = any

Ports:
clk  input  1  system clock; sole clock domain
reset_n  input  1  asynchronous, active-low reset
address  input  2  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  registered read data
in_port  input  WIDTH  raw asynchronous pin inputs
irq  output  1  level interrupt, active high

Behaviour:
- One clock domain. reset_n asserts asynchronously and clears all state immediately, including mid-debounce and mid-read. Release is synchronous to clk.
- Reset values:
  - sync chain, debounced value deb, counters: 0
  - edge_capture, irq_mask: 0
  - readdata: 0
  - irq: 0
- Synchroniser: in_port passes through SYNC_STAGES flops; the output is s.
- Debounce, per bit i, with DEBOUNCE_CYCLES = N > 0:
  - If s[i] == deb[i]: cnt[i] <= 0.
  - Else if cnt[i] == N-1: deb[i] <= s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Net effect: deb[i] updates on the Nth consecutive edge where s[i] differs from deb[i]. Any bounce restarts the count.
  - Counter width is clog2(N), minimum 1. When N = 0, deb = s (combinational passthrough, no counter).
- Edge detect: deb_d is deb delayed one cycle. Edge terms:
  - rise = deb & ~deb_d
  - fall = ~deb & deb_d
  - EDGE_TYPE selects rise, fall, or rise|fall.
- Edge capture bit set: the cycle after deb changes.
- Register map (word address):
  - 0 DATA, RO: {zeros, deb}. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK, RW: bits [WIDTH-1:0]. Upper bits read 0.
  - 3 EDGE_CAPTURE, RW1C: a write of 1 clears that bit; a write of 0 leaves it unchanged.
- A write occurs when chipselect = 1 and write_n = 0 at the clock edge. It takes effect on that edge.
- Read: readdata <= mux(address) on every clock edge, whatever the state of chipselect. Read latency is 1 cycle. A read reflects register state before any write on the same edge.
- Clear/set collision: if an edge-set and a W1C clear hit the same bit on the same edge, the set wins and the bit stays 1.
- irq = |(edge_capture & irq_mask), driven combinationally from registers. It stays asserted until software clears capture or mask.
- Known effect at power-up: with deb reset to 0, an input held high during reset produces a rising edge after the debounce time. irq_mask resets to 0, so no interrupt fires unless software enables it.
- Input to DATA latency with N > 0: SYNC_STAGES + N cycles until deb changes, plus 1 cycle for readdata.

Test Plan:
1. Reset, defaults (WIDTH=10, SYNC=2, N=4): hold reset_n=0, drive in_port=0x3FF, read all addresses -> readdata=0 and irq=0. Assert reset_n=0 mid-count -> deb stays 0.
2. Clean step: in_port 0x000 -> 0x001, read addr 0 every cycle -> DATA becomes 0x001 exactly 2+4+1 = 7 cycles after the step. Reading addr 3 then gives 0x001.
3. Bounce: toggle in_port[0] high 3 cycles, low 1, high 5 -> deb[0] rises only after 4 consecutive high cycles. Edge capture sets exactly once (0x001).
4. IRQ: write IRQ_MASK=0x001 -> irq=1. Write 0x001 to addr 3 -> capture becomes 0 and irq drops the next cycle. Writing 0x000 to addr 3 leaves capture unchanged.
5. Collision: time a W1C of bit 0 to the same edge as a new rising edge on bit 0 -> capture[0] remains 1 and irq stays high.
6. Parameters: WIDTH=32, N=0, EDGE_TYPE=2 -> DATA follows in_port after 2+1 cycles. Both the rise and the fall of bit 31 set capture[31]. Reads of addr 1 return 0.
